// File: rtl/keypad_digit_capture.sv
`default_nettype none
// ============================================================================
// Module   : keypad_digit_capture
// Purpose  : Latches the row/column pair on each keypad scanner press strobe
//            and decodes it to a hex key code. The key is confirmed by a
//            debounce hold on the scanner's key-held flag. It is then shifted
//            into a two-digit history that feeds a dual seven-segment driver.
//            Exactly one digit is committed per physical key press.
// Ports    : clk        - system clock
//            reset      - asynchronous, active-low reset
//            rows[3:0]  - scanner row drive (one-hot during a scan-check)
//            cols[3:0]  - synchronized column sense, active-high
//            press      - scanner strobe: some column is high this scan-check
//            change     - scanner key-held flag
//            digit_new  - most recently committed key code
//            digit_old  - previously committed key code
//            new_digit  - one-cycle pulse in the cycle after a commit
//            busy       - high whenever the capture FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module keypad_digit_capture #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  input  logic [3:0] cols,
  input  logic       press,
  input  logic       change,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       new_digit,
  output logic       busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       digit_new_q, digit_new_d;
  logic [3:0]       digit_old_q, digit_old_d;
  logic             new_digit_q, new_digit_d;
  logic             busy_q, busy_d;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Keypad legend: rows top-to-bottom, cols[0] is the leftmost column.
  function automatic logic [3:0] decode_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = 4'h0;
    case ({r, c})
      4'd0:  k = 4'h1;
      4'd1:  k = 4'h2;
      4'd2:  k = 4'h3;
      4'd3:  k = 4'hA;
      4'd4:  k = 4'h4;
      4'd5:  k = 4'h5;
      4'd6:  k = 4'h6;
      4'd7:  k = 4'hB;
      4'd8:  k = 4'h7;
      4'd9:  k = 4'h8;
      4'd10: k = 4'h9;
      4'd11: k = 4'hC;
      4'd12: k = 4'hE;
      4'd13: k = 4'h0;
      4'd14: k = 4'hF;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  logic       capture_ok;
  logic [3:0] key_code;

  assign capture_ok = press && is_onehot(rows) && is_onehot(cols);
  assign key_code   = decode_key(onehot_index(rows), onehot_index(cols));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
    new_digit_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (capture_ok) begin
          code_d  = key_code;
          cnt_d   = '0;
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (!change) begin
          // Bounce: the captured code is simply abandoned.
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          digit_old_d = digit_new_q;
          digit_new_d = code_q;
          new_digit_d = 1'b1;
          state_d     = ST_HELD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        // Re-scans of a held key arrive as press strobes; they are ignored
        // until the scanner reports the key released.
        if (!change) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered from the next state so busy tracks state with no extra lag.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      code_q      <= 4'd0;
      digit_new_q <= 4'd0;
      digit_old_q <= 4'd0;
      new_digit_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
      new_digit_q <= new_digit_d;
      busy_q      <= busy_d;
    end
  end

  assign digit_new = digit_new_q;
  assign digit_old = digit_old_q;
  assign new_digit = new_digit_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_digit_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_digit_capture
// Purpose  : Self-checking bench for keypad_digit_capture (DEBOUNCE_CYCLES=4).
//            Directed scenarios plus random scanner traffic, all compared
//            cycle by cycle against a behavioural model of the key history.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_digit_capture;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows = 4'd0;
  logic [3:0] cols = 4'd0;
  logic       press = 1'b0;
  logic       change = 1'b0;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       new_digit;
  logic       busy;

  keypad_digit_capture #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .press     (press),
    .change    (change),
    .digit_new (digit_new),
    .digit_old (digit_old),
    .new_digit (new_digit),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Key legend indexed by row*4+col.
  int key_map [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  bit armed;        // a key was captured and is being qualified
  bit locked;       // a key was committed and is still held
  int held_run;     // consecutive change-high cycles since capture
  int pending_key;
  int hist_new, hist_old;
  bit exp_pulse;
  int pulse_count;

  function automatic int bit_pos(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    armed = 0; locked = 0; held_run = 0; pending_key = 0;
    hist_new = 0; hist_old = 0; exp_pulse = 0;
  endtask

  // One rising edge with the given inputs.
  task automatic model_step(input bit p, input logic [3:0] r, input logic [3:0] c, input bit ch);
    exp_pulse = 0;
    if (armed) begin
      if (!ch) armed = 0;
      else begin
        held_run++;
        if (held_run == DEB) begin
          hist_old = hist_new;
          hist_new = pending_key;
          exp_pulse = 1;
          armed = 0;
          locked = 1;
        end
      end
    end else if (locked) begin
      if (!ch) locked = 0;
    end else if (p && $countones(r) == 1 && $countones(c) == 1) begin
      pending_key = key_map[bit_pos(r) * 4 + bit_pos(c)];
      held_run = 0;
      armed = 1;
    end
  endtask

  task automatic compare_all(input string where);
    check({where, ".digit_new"}, 32'(digit_new), 32'(hist_new));
    check({where, ".digit_old"}, 32'(digit_old), 32'(hist_old));
    check({where, ".new_digit"}, 32'(new_digit), 32'(exp_pulse));
    check({where, ".busy"},      32'(busy),      32'(armed || locked));
  endtask

  // Drive inputs on the falling edge, advance the model on the rising edge,
  // then compare 1 time unit later.
  task automatic cyc(input bit p, input logic [3:0] r, input logic [3:0] c, input bit ch,
                     input string where);
    @(negedge clk);
    press = p; rows = r; cols = c; change = ch;
    @(posedge clk);
    if (reset) model_step(p, r, c, ch);
    #1;
    if (new_digit) pulse_count++;
    compare_all(where);
  endtask

  // Asynchronous reset asserted mid-cycle: outputs must clear at once.
  task automatic async_reset(input string where);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check({where, ".rst_new"},   32'(digit_new), 32'd0);
    check({where, ".rst_old"},   32'(digit_old), 32'd0);
    check({where, ".rst_pulse"}, 32'(new_digit), 32'd0);
    check({where, ".rst_busy"},  32'(busy),      32'd0);
    cyc(0, 4'd0, 4'd0, 0, where);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    pulse_count = 0;

    // Power-on reset, then release.
    #12;
    check("por.busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 4'd0, 4'd0, 0, "idle");

    // Commit something first so a later reset has visible state to clear.
    cyc(1, 4'b0001, 4'b0001, 1, "pre");
    for (int i = 0; i < DEB; i++) cyc(0, 4'd0, 4'd0, 1, "pre");
    check("pre.digit", 32'(digit_new), 32'd1);
    cyc(0, 4'd0, 4'd0, 0, "pre_rel");
    async_reset("reset1");
    check("reset1.idle_busy", 32'(busy), 32'd0);

    // Single key: row 1, col 2 -> 6. Pulse exactly in cycle N+5.
    cyc(1, 4'b0010, 4'b0100, 1, "single");
    check("single.busy_n1", 32'(busy), 32'd1);
    for (int i = 0; i < DEB - 1; i++) begin
      cyc(0, 4'd0, 4'd0, 1, "single");
      check("single.no_early", 32'(new_digit), 32'd0);
    end
    cyc(0, 4'd0, 4'd0, 1, "single");
    check("single.pulse", 32'(new_digit), 32'd1);
    check("single.new", 32'(digit_new), 32'h6);
    check("single.old", 32'(digit_old), 32'h0);
    cyc(0, 4'd0, 4'd0, 1, "single");
    check("single.pulse_end", 32'(new_digit), 32'd0);
    cyc(0, 4'd0, 4'd0, 0, "single_rel");

    // Sequence: key 0 (row 3, col 1), then key A (row 0, col 3).
    cyc(1, 4'b1000, 4'b0010, 1, "seq0");
    for (int i = 0; i < DEB; i++) cyc(0, 4'd0, 4'd0, 1, "seq0");
    check("seq0.new", 32'(digit_new), 32'h0);
    check("seq0.old", 32'(digit_old), 32'h6);
    cyc(0, 4'd0, 4'd0, 0, "seq0_rel");
    cyc(1, 4'b0001, 4'b1000, 1, "seqA");
    for (int i = 0; i < DEB; i++) cyc(0, 4'd0, 4'd0, 1, "seqA");
    check("seqA.new", 32'(digit_new), 32'hA);
    check("seqA.old", 32'(digit_old), 32'h0);
    cyc(0, 4'd0, 4'd0, 0, "seqA_rel");

    // Bounce: change drops in N+2, busy low by N+3, history unchanged.
    cyc(1, 4'b0100, 4'b0001, 1, "bounce");
    cyc(0, 4'd0, 4'd0, 1, "bounce");
    cyc(0, 4'd0, 4'd0, 0, "bounce");
    check("bounce.busy", 32'(busy), 32'd0);
    for (int i = 0; i < DEB + 2; i++) cyc(0, 4'd0, 4'd0, 0, "bounce");
    check("bounce.hist", 32'({digit_new, digit_old}), 32'hA0);

    // Held key with re-press strobes: exactly one pulse. Then the same key
    // again right after release must commit a duplicate.
    pulse_count = 0;
    cyc(1, 4'b0010, 4'b0010, 1, "held");
    for (int i = 1; i < 100; i++)
      cyc((i % 8) == 0, 4'b0010, 4'b0010, 1, "held");
    check("held.pulses", 32'(pulse_count), 32'd1);
    cyc(0, 4'd0, 4'd0, 0, "held_rel");
    cyc(1, 4'b0010, 4'b0010, 1, "held_again");
    for (int i = 0; i < DEB; i++) cyc(0, 4'd0, 4'd0, 1, "held_again");
    check("dup.hist", 32'({digit_new, digit_old}), 32'h55);
    cyc(0, 4'd0, 4'd0, 0, "dup_rel");

    // Illegal captures: multi-key column, then no row.
    cyc(1, 4'b0001, 4'b0110, 1, "multi");
    check("multi.busy", 32'(busy), 32'd0);
    cyc(1, 4'b0000, 4'b0100, 1, "norow");
    check("norow.busy", 32'(busy), 32'd0);
    for (int i = 0; i < DEB + 1; i++) cyc(0, 4'd0, 4'd0, 1, "illegal");
    check("illegal.hist", 32'({digit_new, digit_old}), 32'h55);
    cyc(0, 4'd0, 4'd0, 0, "illegal");

    // Reset while debouncing at counter 2: nothing may commit afterwards.
    cyc(1, 4'b0100, 4'b0100, 1, "rst_deb");
    cyc(0, 4'd0, 4'd0, 1, "rst_deb");
    cyc(0, 4'd0, 4'd0, 1, "rst_deb");
    async_reset("rst_deb");
    pulse_count = 0;
    for (int i = 0; i < DEB + 2; i++) cyc(0, 4'd0, 4'd0, 1, "rst_deb_after");
    check("rst_deb.pulses", 32'(pulse_count), 32'd0);
    cyc(0, 4'd0, 4'd0, 0, "rst_deb_after");

    // Random scanner traffic with a sticky key-held flag.
    begin
      bit         ch;
      bit         p;
      logic [3:0] r, c;
      int         sel;
      ch = 0;
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 6) == 0) ch = ~ch;
        p = ($urandom_range(0, 2) == 0);
        sel = $urandom_range(0, 9);
        r = (sel < 8) ? 4'(1 << (sel % 4)) : ((sel == 8) ? 4'd0 : 4'($urandom));
        sel = $urandom_range(0, 9);
        c = (sel < 8) ? 4'(1 << (sel % 4)) : ((sel == 8) ? 4'd0 : 4'($urandom));
        cyc(p, r, c, ch, "rand");
        if ($urandom_range(0, 399) == 0) async_reset("rand_rst");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/keypad_digit_capture.md
# keypad_digit_capture

Downstream consumer of the keypad row scanner. On each scanner `press` strobe it latches the active row/column pair and decodes it to a 4-bit hex key code. It confirms the key with a debounce hold qualified by the scanner's `change` (key-held) flag, then shifts the key into a two-digit history that feeds the dual seven-segment display driver. Exactly one digit is committed per physical key press; held keys and bounces never repeat.

## Interface
- `DEBOUNCE_CYCLES`, default 20000: number of consecutive `change`-high cycles required to commit a key. Legal range is ≥ 2. The counter width is `$clog2(DEBOUNCE_CYCLES)`.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `rows` input, 4 bits: scanner row drive. During a scan-check cycle exactly one bit is high, and that bit is the row under test.
- `cols` input, 4 bits: synchronized column sense, active-high.
- `press` input, 1 bit: scanner strobe, high in a scan-check cycle when any column is high.
- `change` input, 1 bit: scanner flag, high while the scanner sits in a key-held state.
- `digit_new` output, 4 bits: most recently committed key code.
- `digit_old` output, 4 bits: previous committed key code.
- `new_digit` output, 1 bit: registered one-cycle pulse in the cycle after a commit.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- **Reset values:** `digit_new` = 0, `digit_old` = 0, `new_digit` = 0, `busy` = 0, state = IDLE, debounce counter = 0, captured code = 0.
- **Decode map:** codes are given by (row, col).
  - Row 0: 1, 2, 3, A.
  - Row 1: 4, 5, 6, B.
  - Row 2: 7, 8, 9, C.
  - Row 3: E, 0, F, D.
  - Column index 0 is `cols[0]`.
- **Capture validity:** a capture is valid only when `press`=1, `rows` is one-hot and `cols` is one-hot.
  - A press with two or more column bits set (multi-key) is discarded. The block stays in IDLE and the history is unchanged.
- **State machine:**
  - **IDLE:** on a valid capture, register the decoded code, clear the counter and go to DEBOUNCE. Otherwise stay in IDLE.
  - **DEBOUNCE:**
    - If `change`=0, go to IDLE. This is a glitch: nothing is committed and the captured code is dropped.
    - Else, if the counter equals `DEBOUNCE_CYCLES-1`, commit: `digit_old` ← `digit_new`, `digit_new` ← captured code, set the `new_digit` register, go to HELD.
    - Else, counter + 1.
  - **HELD:** stay while `change`=1. When `change`=0, go to IDLE. `press` is ignored in this state.
- `press` is ignored outside IDLE, so a re-scan during the hold cannot retrigger a commit.
- The counter is only cleared on capture. It does not wrap, because commit or exit always happens first.
- `new_digit` is high for exactly one cycle per commit.
- **Repeated keys:** the same key pressed twice shifts twice. For example, with history (5, 3), pressing 5 gives `digit_old`=5, `digit_new`=5.
- **Reset mid-operation:** asserting `reset` in any state immediately forces all reset values. A pending capture is lost and any in-flight `new_digit` pulse is cleared.

## Timing
- Let `press` be valid in cycle N.
  - State is DEBOUNCE from cycle N+1, with the counter at k-1 in cycle N+k.
  - If `change` stays 1 through cycle N+`DEBOUNCE_CYCLES`, the commit edge ends that cycle.
  - The outputs update, and `new_digit`=1, in cycle N+`DEBOUNCE_CYCLES`+1.
- A `change`=0 sample in any DEBOUNCE cycle aborts; IDLE follows in the next cycle.
- **Minimum re-arm after release:** `change`=0 in HELD gives IDLE in the next cycle. A `press` in that IDLE cycle is accepted.
- `busy` is a registered decode of state, so it rises in cycle N+1.
- All outputs are registered. There is no combinational path from the inputs to the outputs.

## Test plan
Use `DEBOUNCE_CYCLES`=4 throughout.
- **Reset:** assert `reset`=0 asynchronously mid-cycle → all outputs 0 immediately; after release, state is IDLE and `busy`=0.
- **Single key:** `rows`=0010, `cols`=0100, `press` pulse at cycle N, `change`=1 held → `new_digit`=1 only in cycle N+5, `digit_new`=6, `digit_old`=0.
- **Sequence:** commit key 6, release, then press `rows`=1000, `cols`=0010 → `digit_new`=0, `digit_old`=6. Then press `rows`=0001, `cols`=1000 → `digit_new`=A, `digit_old`=0.
- **Bounce:** valid press, then `change` drops in cycle N+2 → no `new_digit`, history unchanged, `busy`=0 by cycle N+3.
- **Held key:** `change` held for 100 cycles with `press` re-pulsing every 8 cycles → exactly one `new_digit` pulse. After release and one IDLE cycle, a new press of the same key commits again and the history shows a duplicate.
- **Illegal input:** `press` with `cols`=0110 or `rows`=0000 → stays IDLE, `busy`=0, no commit. Separately, assert `reset` in DEBOUNCE at counter 2 → no commit after release.
